// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM switch datapath: default geometry, index-width helper
// and the deframer FSM state type.
package gsm_pkg;

  localparam int MWIDTH_DEF = 4;
  localparam int GSIZE_DEF  = 8;
  localparam int DWIDTH_DEF = 128;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/gsm_serial_deframer_if.sv
// Word-parallel output stream of the serial deframer: the word with its frame index
// and last flag, under a valid/ready handshake.
interface gsm_serial_deframer_if
  import gsm_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int IW     = idx_width(MWIDTH_DEF * GSIZE_DEF)
);

  logic [DWIDTH-1:0] word_o;
  logic [IW-1:0]     widx_o;
  logic              last_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output word_o,
    output widx_o,
    output last_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  word_o,
    input  widx_o,
    input  last_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/gsm_word_fifo2.sv
// Two-entry FIFO between the deframer and the group loader. A push is accepted while
// full as long as a pop happens in the same cycle.
module gsm_word_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  // Empty reads as zero so the downstream bus idles at its reset value.
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gsm_serial_deframer.sv
// Bit-serial to word-parallel deframer: rebuilds MSB-first words of one switch frame
// and queues them, with index and last flag, towards the group loader.
module gsm_serial_deframer
  import gsm_pkg::*;
#(
  parameter int MWIDTH = MWIDTH_DEF,
  parameter int GSIZE  = GSIZE_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   sig_i,
  input  logic                   en_i,
  input  logic                   sof_i,
  gsm_serial_deframer_if.master  out_if,
  output logic                   busy_o,
  output logic                   ovf_o,
  output logic                   ferr_o
);

  localparam int NWORDS = MWIDTH * GSIZE;
  localparam int IW     = idx_width(NWORDS);
  localparam int BW     = idx_width(DWIDTH);
  localparam int FW     = DWIDTH + IW + 1;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [IW-1:0]     wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] push_word;
  logic              push_last;
  logic [FW-1:0]     fifo_dout;

  assign push_word = {sreg_q[DWIDTH-2:0], sig_i};
  assign push_last = (wcnt_q == IW'(NWORDS - 1));
  assign pop       = !fifo_empty && out_if.ready_i;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && sof_i) begin
          sreg_d  = {{(DWIDTH-1){1'b0}}, sig_i};
          bcnt_d  = BW'(1);
          wcnt_d  = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        // A restart beats word completion: the sof bit always opens word 0 afresh.
        if (en_i && sof_i) begin
          ferr_d = 1'b1;
          sreg_d = {{(DWIDTH-1){1'b0}}, sig_i};
          bcnt_d = BW'(1);
          wcnt_d = '0;
        end else if (en_i) begin
          sreg_d = push_word;
          if (bcnt_q == BW'(DWIDTH - 1)) begin
            push   = 1'b1;
            bcnt_d = '0;
            if (push_last) begin
              wcnt_d  = '0;
              state_d = IDLE;
            end else begin
              wcnt_d = wcnt_q + IW'(1);
            end
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  gsm_word_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clr_n),
    .push_i  (push),
    .data_i  ({push_word, wcnt_q, push_last}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {out_if.word_o, out_if.widx_o, out_if.last_o} = fifo_dout;
  assign out_if.valid_o = !fifo_empty;
  assign busy_o         = (state_q == RECV);
  assign ovf_o          = ovf_q;
  assign ferr_o         = ferr_q;

endmodule
